// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM state and element types for the 2x2 convolution engine
package conv_pkg;
  localparam int MAT_N  = 4;
  localparam int KER_N  = 2;
  localparam int OUT_N  = 3;
  localparam int ELEM_W = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_M,
    S_CALC_WR,
    S_DONE
  } state_t;

  typedef logic signed [ELEM_W-1:0] elem_t;
endpackage

// File: rtl/conv_mac4.sv
// rtl/conv_mac4.sv - combinational sum of four signed element products, sign-extended to DATA_W
module conv_mac4
  import conv_pkg::*;
(
  input  elem_t                    i_m [4],
  input  elem_t                    i_k [4],
  output logic signed [DATA_W-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < 4; i++) begin
      o_sum = o_sum + DATA_W'(i_m[i]) * DATA_W'(i_k[i]);
    end
  end

endmodule

// File: rtl/conv2x2_mem_engine.sv
// rtl/conv2x2_mem_engine.sv - bus-mastering 4x4 by 2x2 valid cross-correlation engine
// Optional CONV_RELU_EN: negative results are written as zero.
module conv2x2_mem_engine
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  input  logic [7:0] matrix_addr,
  input  logic [7:0] kernel_addr,
  input  logic [7:0] output_addr,
  output logic       mem_w,
  output logic       mem_sel,
  inout  wire  [7:0] address_bus,
  inout  wire  [31:0] data_bus
);

  state_t                    r_state;
  logic [3:0]                r_idx;
  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W-1:0]         r_mat_base;
  logic [ADDR_W-1:0]         r_ker_base;
  logic [ADDR_W-1:0]         r_out_base;
  elem_t                     r_k [4];
  elem_t                     r_m [16];

  logic [1:0]                w_row;
  logic [1:0]                w_col;
  elem_t                     w_m_sel [4];
  logic signed [DATA_W-1:0]  w_sum;
  logic [DATA_W-1:0]         w_wdata;

  // Output index r_idx maps to (row, col) of the 3x3 result.
  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    case (r_idx)
      4'd0: begin w_row = 2'd0; w_col = 2'd0; end
      4'd1: begin w_row = 2'd0; w_col = 2'd1; end
      4'd2: begin w_row = 2'd0; w_col = 2'd2; end
      4'd3: begin w_row = 2'd1; w_col = 2'd0; end
      4'd4: begin w_row = 2'd1; w_col = 2'd1; end
      4'd5: begin w_row = 2'd1; w_col = 2'd2; end
      4'd6: begin w_row = 2'd2; w_col = 2'd0; end
      4'd7: begin w_row = 2'd2; w_col = 2'd1; end
      4'd8: begin w_row = 2'd2; w_col = 2'd2; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  always_comb begin
    for (int a = 0; a < KER_N; a++) begin
      for (int b = 0; b < KER_N; b++) begin
        w_m_sel[a*2+b] = r_m[{w_row + 2'(a), w_col + 2'(b)}];
      end
    end
  end

  conv_mac4 u_mac (
    .i_m   (w_m_sel),
    .i_k   (r_k),
    .o_sum (w_sum)
  );

`ifdef CONV_RELU_EN
  assign w_wdata = w_sum[DATA_W-1] ? '0 : w_sum;
`else
  assign w_wdata = w_sum;
`endif

  assign address_bus = mem_sel ? r_addr : 'z;
  assign data_bus    = (mem_sel && mem_w) ? w_wdata : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_addr     <= '0;
      r_mat_base <= '0;
      r_ker_base <= '0;
      r_out_base <= '0;
      done       <= 1'b0;
      mem_w      <= 1'b0;
      mem_sel    <= 1'b0;
      for (int i = 0; i < 4; i++)  r_k[i] <= '0;
      for (int i = 0; i < 16; i++) r_m[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mat_base <= matrix_addr;
            r_ker_base <= kernel_addr;
            r_out_base <= output_addr;
            done       <= 1'b0;
            r_idx      <= '0;
            r_addr     <= kernel_addr;
            mem_sel    <= 1'b1;
            mem_w      <= 1'b0;
            r_state    <= S_LOAD_K;
          end
        end
        S_LOAD_K: begin
          r_k[r_idx[1:0]] <= elem_t'(data_bus[ELEM_W-1:0]);
          if (r_idx == 4'd3) begin
            r_idx   <= '0;
            r_addr  <= r_mat_base;
            r_state <= S_LOAD_M;
          end else begin
            r_idx  <= r_idx + 4'd1;
            r_addr <= r_addr + 8'd1;
          end
        end
        S_LOAD_M: begin
          r_m[r_idx] <= elem_t'(data_bus[ELEM_W-1:0]);
          if (r_idx == 4'd15) begin
            r_idx   <= '0;
            r_addr  <= r_out_base;
            mem_w   <= 1'b1;
            r_state <= S_CALC_WR;
          end else begin
            r_idx  <= r_idx + 4'd1;
            r_addr <= r_addr + 8'd1;
          end
        end
        S_CALC_WR: begin
          if (r_idx == 4'd8) begin
            r_idx   <= '0;
            done    <= 1'b1;
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_idx  <= r_idx + 4'd1;
            r_addr <= r_addr + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2x2_mem_engine.sv
// tb/tb_conv2x2_mem_engine.sv - self-checking bench with bus memory and reference convolution
module tb_conv2x2_mem_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic [7:0]  matrix_addr;
  logic [7:0]  kernel_addr;
  logic [7:0]  output_addr;
  logic        mem_w;
  logic        mem_sel;
  wire  [7:0]  address_bus;
  wire  [31:0] data_bus;

  conv2x2_mem_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .matrix_addr (matrix_addr),
    .kernel_addr (kernel_addr),
    .output_addr (output_addr),
    .mem_w       (mem_w),
    .mem_sel     (mem_sel),
    .address_bus (address_bus),
    .data_bus    (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus memory: combinational read, posedge write; host port used only while idle.
  logic [31:0] mem [256];
  logic        h_we;
  logic [7:0]  h_addr;
  logic [31:0] h_data;

  assign data_bus = (mem_sel && !mem_w) ? mem[address_bus] : 'z;

  always @(posedge clk) begin
    if (mem_sel && mem_w) mem[address_bus] <= data_bus;
    else if (h_we)        mem[h_addr]      <= h_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%08h) expected=%0d (0x%08h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  int         mv [16];
  int         kv [4];
  int         sm [16];
  int         sk [4];
  int         exp_y [9];
  logic [7:0] mb, kb, ob;
  int         cyc;

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    h_we = 1'b1; h_addr = a; h_data = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  // Loads operands with junk upper bits, then derives the expected results from memory contents.
  task automatic load_and_model();
    for (int i = 0; i < 16; i++) host_write(8'(mb + i), {24'($urandom), 8'(mv[i])});
    for (int i = 0; i < 4; i++)  host_write(8'(kb + i), {24'($urandom), 8'(kv[i])});
    for (int i = 0; i < 16; i++) sm[i] = int'($signed(mem[8'(mb + i)][7:0]));
    for (int i = 0; i < 4; i++)  sk[i] = int'($signed(mem[8'(kb + i)][7:0]));
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int s;
        s = 0;
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++)
            s += sm[(r + a) * 4 + c + b] * sk[a * 2 + b];
        exp_y[r * 3 + c] = relu(s);
      end
    end
  endtask

  task automatic run_op(input string nm, input int restart_at, input int rst_at, output bit aborted);
    aborted = 1'b0;
    matrix_addr = mb; kernel_addr = kb; output_addr = ob;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    matrix_addr = 8'($urandom); kernel_addr = 8'($urandom); output_addr = 8'($urandom);
    chk({nm, " first_addr"}, 32'(address_bus), 32'(kb));
    chk({nm, " done_cleared"}, 32'(done), 32'd0);
    while (!done && cyc < 100) begin
      start = (cyc == restart_at);
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk({nm, " abort_mem_sel"}, 32'(mem_sel), 32'd0);
        chk({nm, " abort_mem_w"}, 32'(mem_w), 32'd0);
        chk({nm, " abort_done"}, 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        aborted = 1'b1;
        return;
      end
    end
    chk({nm, " latency"}, 32'(cyc), 32'd29);
    chk({nm, " bus_released"}, 32'(mem_sel), 32'd0);
    for (int o = 0; o < 9; o++) chk($sformatf("%s y%0d", nm, o), mem[8'(ob + o)], 32'(exp_y[o]));
  endtask

  typedef struct {
    string nm;
    int    mode;
    int    k0, k1, k2, k3;
    int    mbase, kbase, obase;
    int    exp0;
  } vec_t;

  vec_t tbl [4];
  bit   ab;

  initial begin
    tbl[0] = '{"diag",  0, 1, 0, 0, -1, 0, 16, 20, relu(-5)};
    tbl[1] = '{"ones",  0, 1, 1, 1, 1, 0, 16, 20, 14};
    tbl[2] = '{"neg",   1, -128, -128, -128, -128, 40, 60, 70, 65536};
    tbl[3] = '{"wrap",  0, 1, 0, 0, -1, 0, 16, 250, relu(-5)};

    rst = 1'b0; start = 1'b0; h_we = 1'b0; h_addr = '0; h_data = '0;
    matrix_addr = '0; kernel_addr = '0; output_addr = '0;
    #3;
    chk("reset done", 32'(done), 32'd0);
    chk("reset mem_sel", 32'(mem_sel), 32'd0);
    chk("reset mem_w", 32'(mem_w), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) mv[i] = (tbl[v].mode == 0) ? i + 1 : -128;
      kv[0] = tbl[v].k0; kv[1] = tbl[v].k1; kv[2] = tbl[v].k2; kv[3] = tbl[v].k3;
      mb = 8'(tbl[v].mbase); kb = 8'(tbl[v].kbase); ob = 8'(tbl[v].obase);
      load_and_model();
      run_op(tbl[v].nm, -1, -1, ab);
      chk({tbl[v].nm, " table_y0"}, mem[ob], 32'(tbl[v].exp0));
      chk({tbl[v].nm, " done_held"}, 32'(done), 32'd1);
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mv[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 4; i++)  kv[i] = int'($urandom_range(0, 255)) - 128;
      mb = 8'($urandom); kb = 8'($urandom); ob = 8'($urandom);
      load_and_model();
      run_op($sformatf("rand%0d", t), -1, -1, ab);
    end

    for (int i = 0; i < 16; i++) mv[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 4; i++)  kv[i] = int'($urandom_range(0, 255)) - 128;
    mb = 8'd100; kb = 8'd130; ob = 8'd140;
    load_and_model();
    run_op("restart", 8, -1, ab);

    for (int i = 0; i < 9; i++) host_write(8'(ob + i), 32'hdead_0000 + 32'(i));
    run_op("abort", -1, 24, ab);
    chk("abort taken", 32'(ab), 32'd1);
    run_op("after_abort", -1, -1, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
